muldiv_seq: RTL
===============

Name: muldiv_seq

Overview:
- Iterative multi-cycle multiply/divide sequencer for the pipeline's EX stage. Sits beside the single-cycle ALU and executes MULT/MULTU/DIV/DIVU.
- Sequences one shared 33-bit add/sub datapath over 32 iterations and produces HI/LO.
- The hazard unit stalls on `busy`. MFHI/MFLO read `hi`/`lo` once `done` has been seen.

Parameters:
- XLEN, 32, operand width; only 32 is supported.
- ITER, 32, iterations per operation; must equal XLEN.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- rst_n, input, 1, reset; asynchronous, active-low.
- start, input, 1, request pulse; sampled only in IDLE or DONE.
- op, input, 2, operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- in1, input, 32, multiplicand / dividend (rs).
- in2, input, 32, multiplier / divisor (rt).
- cancel, input, 1, synchronous abort from pipeline flush.
- busy, output, 1, high in CALC and FIX.
- done, output, 1, one-cycle pulse, high in DONE.
- hi, output, 32, product[63:32] or remainder.
- lo, output, 32, product[31:0] or quotient.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- State on rst_n=0: state=IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0, operand registers=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE with start=1 (edge E0):
  - Latch op.
  - Signed ops: latch |in1| and |in2|, plus sign flags s1=in1[31], s2=in2[31].
  - Unsigned ops: latch raw operands, flags forced to 0.
  - Clear the 64-bit accumulator; counter=0; go to CALC.
- DONE with start=0: go to IDLE.
- IDLE with start=0: stay in IDLE.
- CALC, one iteration per edge, counter 0..31; after the edge where counter=31, go to FIX (edge E32).
  - Multiply: shift-add, LSB-first. If multiplier bit is set, add the multiplicand to acc[63:32] with 33-bit carry; then shift acc right by 1.
  - Divide: restoring. Shift {rem,quot} left by 1; trial = rem - divisor (33-bit). If non-negative, rem=trial and quot LSB=1.
- FIX (edge E33): write `hi`/`lo`, go to DONE.
  - Signed multiply: if s1^s2, apply 64-bit two's-complement negation of the product.
  - Signed divide: quotient is negated if s1^s2; remainder is negated if s1.
- Latency: done is high during the cycle after E33, i.e. 34 cycles after the start edge. hi/lo are valid from then on and hold until the next FIX.
- Division by zero (in2=0): lo=0xFFFFFFFF, hi=in1 (original, unmodified). Applies to both DIV and DIVU. Produced at the normal latency (or early-out, see below).
- Overflow, DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out of the unsigned-magnitude algorithm with 32-bit wrap and needs no special case.
- start while busy=1: ignored; no state or output change.
- start in DONE: accepted back-to-back. done still pulses for exactly that cycle, and the new operation enters CALC.
- cancel=1: go to IDLE at the next edge from any state; hi/lo keep their previous values and done is not asserted.
  - cancel and start in the same cycle: cancel wins and start is dropped.
- Async reset mid-operation: immediate return to reset values.
- op, in1 and in2 are don't-care outside the start edge.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: if the start edge sees in2==0 (any op) or in1==0 (multiply ops only), skip CALC and go straight to FIX with the result preloaded.
  - Multiply by zero gives hi=lo=0.
  - Divide by zero gives the values defined above.
  - done then pulses 2 cycles after the start edge.
- Not defined: every operation takes the full 34-cycle latency; results are identical in both builds.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> done at cycle 34, hi=0xFFFFFFFE, lo=0x00000001; busy high for cycles 1-33.
- MULT 0xFFFFFFFE (-2) × 0x00000003 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIV -7 / 2, then DIVU 7 / 2:
  - DIV -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU -> lo=3, hi=1.
  - Second start issued in the DONE cycle of the first -> accepted; second done exactly 34 cycles later.
- DIV by zero with in1=0x12345678 -> lo=0xFFFFFFFF, hi=0x12345678 at cycle 34 (cycle 2 with MULDIV_EARLY_OUT_EN).
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Mid-operation events:
  - start pulse at cycle 10 of a busy op -> ignored; the original result is unchanged.
  - cancel at cycle 15 -> IDLE next edge, no done, hi/lo hold their prior values.
  - rst_n low at cycle 20 -> all outputs 0 immediately.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer: one shared add/sub step per cycle, result in 34 cycles.
// Optional MULDIV_EARLY_OUT_EN skips the iterations for zero operands (result in 2 cycles).
module muldiv_seq #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic            cancel,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CNTW = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state_q;
  logic              busy_q, done_q;
  logic [XLEN-1:0]   hi_q, lo_q;
  logic [CNTW-1:0]   cnt_q;
  logic [XLEN-1:0]   a_q, b_q, orig_q;
  logic [2*XLEN-1:0] acc_q;
  logic              div_q, s1_q, s2_q, dz_q;

  logic              signed_op, is_mul_in, s1_in, s2_in, early;
  logic [XLEN-1:0]   mag1, mag2;
  logic [XLEN:0]     mul_sum, div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_trial;
  logic [2*XLEN-1:0] mul_acc_d, div_acc_d, prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, hi_d, lo_d;

  // Operand conditioning on the start edge: magnitudes plus sign flags.
  always_comb begin
    signed_op = ~op[0];
    is_mul_in = ~op[1];
    s1_in     = signed_op & in1[XLEN-1];
    s2_in     = signed_op & in2[XLEN-1];
    mag1      = s1_in ? ('0 - in1) : in1;
    mag2      = s2_in ? ('0 - in2) : in2;
`ifdef MULDIV_EARLY_OUT_EN
    early     = (in2 == '0) || (is_mul_in && (in1 == '0));
`else
    early     = 1'b0;
`endif
  end

  // One iteration of shift-add multiply (LSB first) and restoring divide.
  // b_q holds the multiplier (shifted right) or the dividend (shifted left).
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, a_q};
    mul_acc_d = b_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    div_shift = {acc_q[2*XLEN-1:XLEN], b_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, a_q};
    div_trial = div_shift[XLEN-1:0] - a_q;
    div_acc_d = div_ge ? {div_trial, acc_q[XLEN-2:0], 1'b1}
                       : {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
  end

  // Sign fix-up; flags are zero for unsigned ops so no op check is needed.
  always_comb begin
    prod_fix = (s1_q ^ s2_q) ? ('0 - acc_q) : acc_q;
    quot_fix = (s1_q ^ s2_q) ? ('0 - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    rem_fix  = s1_q ? ('0 - acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
    if (div_q) begin
      hi_d = dz_q ? orig_q : rem_fix;
      lo_d = dz_q ? '1 : quot_fix;
    end else begin
      hi_d = prod_fix[2*XLEN-1:XLEN];
      lo_d = prod_fix[XLEN-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      orig_q  <= '0;
      acc_q   <= '0;
      div_q   <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      dz_q    <= 1'b0;
    end else if (cancel) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            div_q   <= op[1];
            s1_q    <= s1_in;
            s2_q    <= s2_in;
            dz_q    <= op[1] && (in2 == '0);
            orig_q  <= in1;
            a_q     <= is_mul_in ? mag1 : mag2;
            b_q     <= is_mul_in ? mag2 : mag1;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= early ? FIX : CALC;
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          acc_q <= div_q ? div_acc_d : mul_acc_d;
          b_q   <= div_q ? (b_q << 1) : (b_q >> 1);
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNTW'(ITER - 1)) state_q <= FIX;
        end
        FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
